sensor_filter: RTL and testbench

Input conditioning stage directly upstream of the fluid level indicator peripheral: takes the eight raw, asynchronous, bouncing liquid-sensor lines from the pins and produces the clean, clock-synchronous `sensor_in[7:0]` vector the indicator consumes. Each bit is synchronized and then debounced against a shared sample tick. A one-cycle change strobe is provided. An optional thermometer-code plausibility check flags impossible sensor patterns.

---
 rtl/sensor_filter_if.sv | 33 +++
 rtl/sensor_filter.sv | 141 ++++++++++++++
 tb/tb_sensor_filter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_filter_if.sv
// ---------------------------------------------------------------------------
// sensor_filter_if
// Bundles the sensor signals of the sensor_filter block.
//   sensor_raw     : raw, asynchronous sensor pins (WIDTH bits)
//   sensor_out     : debounced, clock-synchronous sensor level (WIDTH bits)
//   sensor_changed : one-cycle strobe when any bit of sensor_out changes
//   sensor_err     : sensor_out is not a thermometer code
// Modports:
//   master : the side that drives the raw pins and consumes the outputs
//   slave  : the filter itself
// ---------------------------------------------------------------------------
interface sensor_filter_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] sensor_raw;
   logic [WIDTH-1:0] sensor_out;
   logic             sensor_changed;
   logic             sensor_err;

   modport master (
      output sensor_raw,
      input  sensor_out,
      input  sensor_changed,
      input  sensor_err
   );

   modport slave (
      input  sensor_raw,
      output sensor_out,
      output sensor_changed,
      output sensor_err
   );
endinterface

// File: rtl/sensor_filter.sv
// ---------------------------------------------------------------------------
// sensor_filter
// Conditions WIDTH raw, bouncing liquid-sensor lines into a clean,
// clock-synchronous level vector. Each bit is passed through a two-flop
// synchronizer and then debounced against a shared prescaled sample tick:
// a new level is accepted only after DEBOUNCE_CNT consecutive ticks that
// all differ from the current output.
//
// Parameters:
//   WIDTH        : number of sensor channels
//   PRESCALE     : clock cycles per sample tick (>= 1)
//   DEBOUNCE_CNT : consecutive differing ticks needed to accept a level (>= 1)
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : sensor_filter_if slave modport (raw in, out/changed/err out)
//
// Optional feature macro: SENSOR_FILTER_FAULT_CHECK_EN
//   Defined   : sensor_err flags a sensor_out that is not a thermometer code.
//   Undefined : sensor_err is tied to 0 and no check logic exists.
// ---------------------------------------------------------------------------
module sensor_filter #(
   parameter int WIDTH        = 8,
   parameter int PRESCALE     = 100000,
   parameter int DEBOUNCE_CNT = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   sensor_filter_if.slave bus
);

   // A PRESCALE of 1 still needs a one-bit counter to keep the ports sane.
   localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   logic [WIDTH-1:0] sync_meta;
   logic [WIDTH-1:0] sync;
   logic [PS_W-1:0]  pre_cnt;
   logic             tick;
   logic [CNT_W-1:0] cnt      [WIDTH];
   logic [CNT_W-1:0] cnt_next [WIDTH];
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_next;
   logic             changed_q;

   // Two-flop synchronizer for every raw pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= bus.sensor_raw;
         sync      <= sync_meta;
      end
   end

   // Free-running prescaler; raw activity never touches it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PS_LAST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PS_W'(1);
      end
   end

   assign tick = (pre_cnt == PS_LAST);

   // Per-channel debounce decision. Any sample that agrees with the current
   // output restarts the count, so only an unbroken run of DEBOUNCE_CNT
   // differing ticks can flip a bit.
   always_comb begin
      out_next = out_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_next[i] = cnt[i];
         if (tick) begin
            if (sync[i] == out_q[i]) begin
               cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
               out_next[i] = sync[i];
               cnt_next[i] = '0;
            end else begin
               cnt_next[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Output level, counters and the change strobe. The strobe is computed
   // from the next-state value so it lines up with the new output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q     <= '0;
         changed_q <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         out_q     <= out_next;
         changed_q <= (out_next != out_q);
         cnt       <= cnt_next;
      end
   end

   assign bus.sensor_out     = out_q;
   assign bus.sensor_changed = changed_q;

`ifdef SENSOR_FILTER_FAULT_CHECK_EN
   logic err_q;
   logic err_next;

   // A level set above a clear level is physically impossible for a
   // liquid column; evaluated on next-state so it moves with sensor_out.
   always_comb begin
      err_next = 1'b0;
      for (int i = 1; i < WIDTH; i++) begin
         if (out_next[i] && !out_next[i-1]) begin
            err_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_next;
      end
   end

   assign bus.sensor_err = err_q;
`else
   assign bus.sensor_err = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_filter.sv
// ---------------------------------------------------------------------------
// tb_sensor_filter
// Self-checking bench for sensor_filter with PRESCALE=4, DEBOUNCE_CNT=3.
// A behavioural reference model runs alongside the DUT; table vectors and
// hand-written sequences cover the directed scenarios, followed by random
// raw activity.
// ---------------------------------------------------------------------------
module tb_sensor_filter;

   localparam int WIDTH    = 8;
   localparam int PRESCALE = 4;
   localparam int DEB      = 3;

   typedef struct {
      logic [7:0] raw;
      int         hold;
      logic [7:0] exp_out;
      int         exp_pulses;
   } vec_t;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;

   sensor_filter_if #(.WIDTH(WIDTH)) bus_if ();

   sensor_filter #(
      .WIDTH        (WIDTH),
      .PRESCALE     (PRESCALE),
      .DEBOUNCE_CNT (DEB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic thermoBad(input logic [7:0] v);
      for (int i = 1; i < 8; i++) begin
         if (v[i] && !v[i-1]) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic expErr(input logic [7:0] v);
`ifdef SENSOR_FILTER_FAULT_CHECK_EN
      return thermoBad(v);
`else
      return 1'b0;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the level seen by the filter is the raw pin two
   // edges late; ticks fall on every PRESCALE-th edge after reset. A bit
   // flips when the last DEB tick samples since its previous flip all
   // disagree with the current level.
   logic [7:0] m_r1, m_r2, m_out, m_sync, m_nxt;
   logic       m_changed, m_err;
   int         m_edge;
   int         m_k;
   bit         m_all;
   logic [7:0] hist[$];
   int         start_idx[8];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_r1 = '0; m_r2 = '0; m_out = '0;
         m_changed = 1'b0; m_err = 1'b0; m_edge = 0;
         hist.delete();
         for (int i = 0; i < 8; i++) start_idx[i] = 0;
      end else begin
         m_sync = m_r2;
         m_r2   = m_r1;
         m_r1   = bus_if.sensor_raw;
         m_edge++;
         m_nxt  = m_out;
         if (m_edge % PRESCALE == 0) begin
            hist.push_back(m_sync);
            m_k = hist.size() - 1;
            for (int i = 0; i < 8; i++) begin
               if (m_k - start_idx[i] + 1 >= DEB) begin
                  m_all = 1'b1;
                  for (int j = m_k - DEB + 1; j <= m_k; j++) begin
                     if (hist[j][i] == m_out[i]) m_all = 1'b0;
                  end
                  if (m_all) begin
                     m_nxt[i]     = ~m_out[i];
                     start_idx[i] = m_k + 1;
                  end
               end
            end
         end
         m_changed = (m_nxt != m_out);
         m_out     = m_nxt;
         m_err     = expErr(m_nxt);
      end
   end

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      checkOutput("model_out", 32'(bus_if.sensor_out), 32'(m_out));
      checkOutput("model_changed", 32'(bus_if.sensor_changed), 32'(m_changed));
      checkOutput("model_err", 32'(bus_if.sensor_err), 32'(m_err));
   end

   task automatic applyStimulus(input logic [7:0] v, input int cycles, output int pulses);
      bus_if.sensor_raw = v;
      pulses = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (bus_if.sensor_changed) pulses++;
      end
   endtask

   vec_t vecs[8];
   int   p, p2, total, c;
   bit   found;
   logic [7:0] v;

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n = 1'b0;
      bus_if.sensor_raw = 8'h00;

      vecs[0] = '{8'h07, 20, 8'h07, 1};
      vecs[1] = '{8'h03, 20, 8'h03, 1};
      vecs[2] = '{8'h0F, 20, 8'h0F, 1};
      vecs[3] = '{8'h0F, 20, 8'h0F, 0};
      vecs[4] = '{8'hFF, 20, 8'hFF, 1};
      vecs[5] = '{8'h01,  5, 8'hFF, 0};
      vecs[6] = '{8'hFF, 20, 8'hFF, 0};
      vecs[7] = '{8'h00, 20, 8'h00, 1};

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset_out", 32'(bus_if.sensor_out), 32'h0);
      checkOutput("reset_changed", 32'(bus_if.sensor_changed), 32'h0);
      checkOutput("reset_err", 32'(bus_if.sensor_err), 32'h0);
      rst_n = 1'b1;

      // Quiet inputs: nothing moves for 100 cycles
      applyStimulus(8'h00, 100, p);
      checkOutput("idle_pulses", 32'(p), 32'h0);
      checkOutput("idle_out", 32'(bus_if.sensor_out), 32'h0);

      // Table vectors
      for (int n = 0; n < 8; n++) begin
         applyStimulus(vecs[n].raw, vecs[n].hold, p);
         checkOutput($sformatf("vec%0d_out", n), 32'(bus_if.sensor_out), 32'(vecs[n].exp_out));
         checkOutput($sformatf("vec%0d_pulses", n), 32'(p), 32'(vecs[n].exp_pulses));
         checkOutput($sformatf("vec%0d_err", n), 32'(bus_if.sensor_err), 32'(expErr(vecs[n].exp_out)));
      end

      // Step to 0x07: visible within 14 cycles with a coincident strobe
      bus_if.sensor_raw = 8'h07;
      found = 1'b0;
      c = 0;
      while (!found && c < 20) begin
         @(negedge clk);
         c++;
         if (bus_if.sensor_out == 8'h07) found = 1'b1;
      end
      checkOutput("step_latency_ok", 32'(found && c <= 14), 32'h1);
      checkOutput("step_strobe", 32'(bus_if.sensor_changed), 32'h1);
      applyStimulus(8'h07, 10, p);
      checkOutput("step_single_pulse", 32'(p), 32'h0);
      applyStimulus(8'h00, 20, p);

      // Glitch spanning two ticks is rejected
      applyStimulus(8'h01, 8, p);
      applyStimulus(8'h00, 20, p2);
      checkOutput("glitch2_out", 32'(bus_if.sensor_out), 32'h0);
      checkOutput("glitch2_pulses", 32'(p + p2), 32'h0);

      // Glitch spanning three ticks is accepted
      applyStimulus(8'h01, 12, p);
      applyStimulus(8'h00, 6, p2);
      checkOutput("glitch3_out", 32'(bus_if.sensor_out), 32'h1);
      checkOutput("glitch3_pulses", 32'(p + p2), 32'h1);
      applyStimulus(8'h00, 20, p);

      // Bit0 steps while bit1 chatters every 5 cycles
      total = 0;
      for (int ph = 0; ph < 8; ph++) begin
         v = (ph % 2 == 1) ? 8'h03 : 8'h01;
         applyStimulus(v, 5, p);
         total += p;
      end
      checkOutput("indep_out", 32'(bus_if.sensor_out), 32'h1);
      checkOutput("indep_pulses", 32'(total), 32'h1);
      applyStimulus(8'h00, 20, p);

      // Non-thermometer pattern and recovery
      applyStimulus(8'h05, 20, p);
      checkOutput("err05_out", 32'(bus_if.sensor_out), 32'h05);
      checkOutput("err05_err", 32'(bus_if.sensor_err), 32'(expErr(8'h05)));
      applyStimulus(8'h07, 20, p);
      checkOutput("err07_out", 32'(bus_if.sensor_out), 32'h07);
      checkOutput("err07_err", 32'(bus_if.sensor_err), 32'h0);

      // Reset in the middle of a count
      applyStimulus(8'h03, 20, p);
      bus_if.sensor_raw = 8'h0F;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_async_out", 32'(bus_if.sensor_out), 32'h0);
      checkOutput("rst_async_changed", 32'(bus_if.sensor_changed), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (9) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_out", 32'(bus_if.sensor_out), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         if (e == 11) checkOutput("rst_rel_early", 32'(bus_if.sensor_out), 32'h0);
         if (e == 12) begin
            checkOutput("rst_rel_out", 32'(bus_if.sensor_out), 32'h0F);
            checkOutput("rst_rel_strobe", 32'(bus_if.sensor_changed), 32'h1);
         end
      end

      // Random raw activity against the model
      for (int r = 0; r < 150; r++) begin
         if ($urandom_range(0, 1) == 1) begin
            v = 8'($urandom);
         end else begin
            v = bus_if.sensor_raw ^ (8'h01 << $urandom_range(0, 7));
         end
         applyStimulus(v, $urandom_range(1, 24), p);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
